regfile_wr_arbiter: RTL and testbench
=====================================

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, write-data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register-address width.
REQ-003 SHALL have parameter CNT_W, default 16, contention-counter width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 a_valid / b_valid  input  1  requester A / B write request pending.
REQ-007 a_addr / b_addr  input  ADDR_W  destination register of A / B.
REQ-008 a_data / b_data  input  DATA_W  write data of A / B.
REQ-009 a_ready / b_ready  output  1  combinational accept strobe for A / B.
REQ-010 wr_stall  input  1  register-file write port busy; hold current write.
REQ-011 wr_en  output  1  registered write-enable to the register file.
REQ-012 wr_addr  output  ADDR_W  registered write address.
REQ-013 wr_data  output  DATA_W  registered write data.
REQ-014 wr_sel_a  output  1  registered source indicator, 1 = A won, 0 = B won; drives downstream 2:1 data/address muxes.
REQ-015 contention_cnt  output  CNT_W  saturating count of cycles where both valid.

Function
REQ-016 Transfer on a requester SHALL occur exactly when its valid and ready are both 1 at a rising edge.
REQ-017 Slot free SHALL be defined as (!wr_en || !wr_stall); no ready SHALL assert when the slot is not free.
REQ-018 Only one valid SHALL grant that requester; both valid SHALL grant the requester not named by the last-grant pointer.
REQ-019 Last-grant pointer SHALL be a two-state machine LAST_A/LAST_B, moving to the winner on each transfer only; otherwise unchanged.
REQ-020 On transfer, next cycle SHALL show wr_en=1 and winner's addr/data, with wr_sel_a set accordingly (latency 1 cycle).
REQ-021 wr_en=1 with wr_stall=1 SHALL hold wr_en, wr_addr, wr_data, wr_sel_a unchanged.
REQ-022 Slot free with no transfer SHALL drive wr_en=0; wr_addr/wr_data/wr_sel_a retain last values.
REQ-023 Back-to-back transfers SHALL be sustained at one per cycle while wr_stall=0.
REQ-024 Requesters SHALL hold valid, addr and data stable until ready; the block does not buffer unaccepted requests.
REQ-025 contention_cnt SHALL increment each cycle a_valid && b_valid, saturating at all-ones with no wrap.
REQ-026 ready outputs SHALL depend only on valids, pointer, wr_en and wr_stall, never on addr/data.

Reset
REQ-027 rst_n=0 at a rising edge SHALL set wr_en=0, wr_addr=0, wr_data=0, wr_sel_a=0, contention_cnt=0, pointer=LAST_B.
REQ-028 While rst_n=0, a_ready and b_ready SHALL be 0; a write in progress or stalled SHALL be discarded.

Configuration
REQ-029 Macro REGFILE_WR_ARB_ZERO_DROP_EN defined: accepted requests with addr==0 SHALL complete the handshake and update the pointer but leave wr_en=0 next cycle.
REQ-030 Macro REGFILE_WR_ARB_ZERO_DROP_EN undefined: addr==0 requests SHALL be written like any other address.

Structure
REQ-031 Package regfile_wr_arb_pkg SHALL hold default DATA_W/ADDR_W/CNT_W constants and the LAST_A/LAST_B pointer state type.
REQ-032 Grant selection SHALL be one combinational sub-module regfile_wr_arb_pick (valids, pointer, slot free -> grants).

Verification
REQ-033 Reset then a_valid=1, a_addr=3, a_data=0x0000_00AA, b idle -> a_ready=1; next cycle wr_en=1, wr_addr=3, wr_data=0xAA, wr_sel_a=1.
REQ-034 Both valid for 4 cycles, addrs 1/2, wr_stall=0, both re-assert after accept -> grants A,B,A,B; contention_cnt=4.
REQ-035 Write to addr 7 pending, wr_stall=1 for 3 cycles with both valid -> outputs frozen, both readys 0; stall drop -> next grant issues the following cycle.
REQ-036 b_valid=1, b_addr=0, data 0x1234 -> macro defined: b_ready=1, wr_en stays 0; macro undefined: wr_en=1, wr_addr=0.
REQ-037 CNT_W=2, both valid 6 cycles -> contention_cnt reaches 3 and holds.
REQ-038 rst_n=0 during stalled write to addr 9 -> next cycle wr_en=0, readys 0, pointer LAST_B; after release tie grants A.

Source files
------------

// File: rtl/regfile_wr_arb_pkg.sv
//==============================================================================
// Module      : regfile_wr_arb_pkg
// Description : Shared constants and types for the register-file write
//               arbiter: default bus widths and the last-grant pointer state.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package regfile_wr_arb_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_CNT_W  = 16;

    // Round-robin pointer: names the requester that won the most recent
    // transfer; on a tie the other requester is granted.
    typedef enum logic [0:0] {
        LAST_A = 1'b0,
        LAST_B = 1'b1
    } last_grant_e;

endpackage : regfile_wr_arb_pkg

`default_nettype wire

// File: rtl/regfile_wr_arbiter_if.sv
//==============================================================================
// Module      : regfile_wr_arbiter_if
// Description : Bundles the two requester handshakes, the register-file write
//               port and the contention counter of the write arbiter.
//   master modport : requester/register-file side (drives valids, addr,
//                    data, wr_stall; observes readys and the write port)
//   slave modport  : arbiter side
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface regfile_wr_arbiter_if #(
    parameter int DATA_W = regfile_wr_arb_pkg::DEF_DATA_W,
    parameter int ADDR_W = regfile_wr_arb_pkg::DEF_ADDR_W,
    parameter int CNT_W  = regfile_wr_arb_pkg::DEF_CNT_W
);

    logic              a_valid;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;

    logic              b_valid;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;

    logic              wr_stall;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_sel_a;

    logic [CNT_W-1:0]  contention_cnt;

    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        output wr_stall,
        input  a_ready, b_ready,
        input  wr_en, wr_addr, wr_data, wr_sel_a,
        input  contention_cnt
    );

    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        input  wr_stall,
        output a_ready, b_ready,
        output wr_en, wr_addr, wr_data, wr_sel_a,
        output contention_cnt
    );

endinterface : regfile_wr_arbiter_if

`default_nettype wire

// File: rtl/regfile_wr_arb_pick.sv
//==============================================================================
// Module      : regfile_wr_arb_pick
// Description : Combinational grant selection for two requesters.
//   a_valid, b_valid : pending requests
//   last             : last-grant pointer (winner of previous transfer)
//   slot_free        : write slot can take a new entry this cycle
//   grant_a, grant_b : one-hot (or zero) grant
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module regfile_wr_arb_pick
    import regfile_wr_arb_pkg::*;
(
    input  wire logic        a_valid,
    input  wire logic        b_valid,
    input  last_grant_e      last,
    input  wire logic        slot_free,
    output logic             grant_a,
    output logic             grant_b
);

    // A lone requester always wins; on a tie the requester that did not
    // win last time is served.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (slot_free) begin
            if (a_valid && b_valid) begin
                grant_a = (last == LAST_B);
                grant_b = (last == LAST_A);
            end else begin
                grant_a = a_valid;
                grant_b = b_valid;
            end
        end
    end

endmodule : regfile_wr_arb_pick

`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
//==============================================================================
// Module      : regfile_wr_arbiter
// Description : Two-requester round-robin arbiter in front of a single
//               register-file write port. One registered write slot; the
//               slot is held while the register file stalls.
//   clk            : clock, rising edge
//   rst_n          : synchronous active-low reset
//   bus (slave)    : requester A/B valid/addr/data/ready, wr_stall input,
//                    registered wr_en/wr_addr/wr_data/wr_sel_a outputs and
//                    saturating contention_cnt
// Build option: REGFILE_WR_ARB_ZERO_DROP_EN - accepted writes to register 0
//               complete the handshake but never raise wr_en.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module regfile_wr_arbiter
    import regfile_wr_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    regfile_wr_arbiter_if.slave   bus
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    last_grant_e       r_last;
    last_grant_e       w_last_next;

    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_wr_sel_a;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_slot_free;
    logic              w_grant_a;
    logic              w_grant_b;
    logic              w_a_ready;
    logic              w_b_ready;
    logic              w_xfer;
    logic              w_drop;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_win_data;

    // The slot can take a new entry when it is empty or its current write
    // leaves at this edge.
    assign w_slot_free = !r_wr_en || !bus.wr_stall;

    regfile_wr_arb_pick u_pick (
        .a_valid   (bus.a_valid),
        .b_valid   (bus.b_valid),
        .last      (r_last),
        .slot_free (w_slot_free),
        .grant_a   (w_grant_a),
        .grant_b   (w_grant_b)
    );

    //--------------------------------------------------------------------------
    // Last-grant pointer FSM
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last <= LAST_B;
        end else begin
            r_last <= w_last_next;
        end
    end

    // Pointer moves only on an actual transfer.
    always_comb begin
        w_last_next = r_last;
        if (w_a_ready) begin
            w_last_next = LAST_A;
        end else if (w_b_ready) begin
            w_last_next = LAST_B;
        end
    end

    // Readys are masked while reset is asserted so nothing is accepted
    // during the reset edge.
    always_comb begin
        w_a_ready = 1'b0;
        w_b_ready = 1'b0;
        if (rst_n) begin
            w_a_ready = w_grant_a;
            w_b_ready = w_grant_b;
        end
    end

    assign w_xfer     = w_a_ready || w_b_ready;
    assign w_win_addr = w_a_ready ? bus.a_addr : bus.b_addr;
    assign w_win_data = w_a_ready ? bus.a_data : bus.b_data;

`ifdef REGFILE_WR_ARB_ZERO_DROP_EN
    assign w_drop = (w_win_addr == '0);
`else
    assign w_drop = 1'b0;
`endif

    //--------------------------------------------------------------------------
    // Write slot
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_wr_sel_a <= 1'b0;
        end else if (w_xfer) begin
            r_wr_en    <= !w_drop;
            r_wr_addr  <= w_win_addr;
            r_wr_data  <= w_win_data;
            r_wr_sel_a <= w_a_ready;
        end else if (w_slot_free) begin
            // Address/data/select keep their last values for the muxes.
            r_wr_en    <= 1'b0;
        end
    end

    //--------------------------------------------------------------------------
    // Contention counter (saturating)
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (bus.a_valid && bus.b_valid && (r_cnt != C_CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus.a_ready        = w_a_ready;
    assign bus.b_ready        = w_b_ready;
    assign bus.wr_en          = r_wr_en;
    assign bus.wr_addr        = r_wr_addr;
    assign bus.wr_data        = r_wr_data;
    assign bus.wr_sel_a       = r_wr_sel_a;
    assign bus.contention_cnt = r_cnt;

endmodule : regfile_wr_arbiter

`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
//==============================================================================
// Module      : tb_regfile_wr_arbiter
// Description : Self-checking bench for regfile_wr_arbiter. A second instance
//               with a 2-bit contention counter shares the same stimulus.
// Build option: REGFILE_WR_ARB_ZERO_DROP_EN changes expected register-0 writes.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_regfile_wr_arbiter;
    import regfile_wr_arb_pkg::*;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int CW  = 16;
    localparam int CW2 = 2;
`ifdef REGFILE_WR_ARB_ZERO_DROP_EN
    localparam bit DROP0 = 1'b1;
`else
    localparam bit DROP0 = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_wr_arbiter_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW))  bus  ();
    regfile_wr_arbiter_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW2)) bus2 ();

    assign bus2.a_valid  = bus.a_valid;
    assign bus2.a_addr   = bus.a_addr;
    assign bus2.a_data   = bus.a_data;
    assign bus2.b_valid  = bus.b_valid;
    assign bus2.b_addr   = bus.b_addr;
    assign bus2.b_data   = bus.b_data;
    assign bus2.wr_stall = bus.wr_stall;

    regfile_wr_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    regfile_wr_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW2)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    // Scoreboard: writes the register file must still see, oldest first.
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          sel_a;
    } wr_t;
    wr_t q[$];

    int tests = 0;
    int fails = 0;

    // Reference state kept at the level of the rules: who won last, what was
    // last accepted, how many contended cycles have been seen.
    bit            model_on   = 1'b0;
    bit            last_was_a = 1'b0;
    logic [AW-1:0] last_addr  = '0;
    logic [DW-1:0] last_data  = '0;
    bit            last_sel   = 1'b0;
    longint        exp_cnt    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic longint sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // One clock of stimulus: drive at negedge+1, check readys and counters at
    // negedge+3, then advance the reference model to the coming edge.
    task automatic step(input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                        input bit bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                        input bit stall, input bit rstv,
                        output bit got_a, output bit got_b);
        bit            free;
        bit            ea;
        bit            eb;
        logic [AW-1:0] wa;
        @(negedge clk);
        #1;
        bus.a_valid  = av;  bus.a_addr = aa; bus.a_data = ad;
        bus.b_valid  = bv;  bus.b_addr = ba; bus.b_data = bd;
        bus.wr_stall = stall;
        rst_n        = rstv;
        #2;
        free = (q.size() == 0) || !stall;
        ea = rstv && free && av && (!bv || !last_was_a);
        eb = rstv && free && bv && (!av || last_was_a);
        got_a = bus.a_ready;
        got_b = bus.b_ready;
        chk("a_ready", bus.a_ready, ea);
        chk("b_ready", bus.b_ready, eb);
        if (model_on) begin
            chk("contention_cnt", bus.contention_cnt, sat(exp_cnt, CW));
            chk("contention_cnt_sat", bus2.contention_cnt, sat(exp_cnt, CW2));
        end
        if (!rstv) begin
            q.delete();
            last_was_a = 1'b0;
            last_addr  = '0;
            last_data  = '0;
            last_sel   = 1'b0;
            exp_cnt    = 0;
            model_on   = 1'b1;
        end else begin
            if (av && bv) exp_cnt++;
            if (ea || eb) begin
                wa         = ea ? aa : ba;
                last_was_a = ea;
                last_addr  = wa;
                last_data  = ea ? ad : bd;
                last_sel   = ea;
                if (!(DROP0 && wa == '0))
                    q.push_back('{addr: wa, data: last_data, sel_a: ea});
            end
        end
    endtask

    // Monitor: checks the write port each cycle after the stimulus settles.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (model_on) begin
                chk("wr_en", bus.wr_en, q.size() != 0);
                if (q.size() != 0) begin
                    chk("wr_addr", bus.wr_addr, q[0].addr);
                    chk("wr_data", bus.wr_data, q[0].data);
                    chk("wr_sel_a", bus.wr_sel_a, q[0].sel_a);
                    if (!bus.wr_stall) void'(q.pop_front());
                end else begin
                    chk("wr_addr_hold", bus.wr_addr, last_addr);
                    chk("wr_data_hold", bus.wr_data, last_data);
                    chk("wr_sel_hold", bus.wr_sel_a, last_sel);
                end
            end
        end
    end

    initial begin
        bit            ga, gb;
        bit            pa, pb;
        bit            st;
        logic [AW-1:0] ra, rb;
        logic [DW-1:0] da, db;

        bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
        bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
        bus.wr_stall = 1'b0;

        // Reset, then single write from A.
        step(0, 0, 0, 0, 0, 0, 0, 0, ga, gb);
        step(0, 0, 0, 0, 0, 0, 0, 0, ga, gb);
        chk("reset_wr_en", bus.wr_en, 0);
        chk("reset_cnt", bus.contention_cnt, 0);
        step(1, 3, 32'hAA, 0, 0, 0, 0, 1, ga, gb);
        chk("single_a_ready", ga, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1, ga, gb);
        chk("single_wr_en", bus.wr_en, 1);
        chk("single_wr_addr", bus.wr_addr, 3);
        chk("single_wr_data", bus.wr_data, 32'hAA);
        chk("single_wr_sel", bus.wr_sel_a, 1);

        // Four contended cycles alternate A,B,A,B.
        step(0, 0, 0, 0, 0, 0, 0, 0, ga, gb);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 32'h100 + i, 1, 2, 32'h200 + i, 0, 1, ga, gb);
            chk("tie_rr_a", ga, (i % 2) == 0);
            chk("tie_rr_b", gb, (i % 2) == 1);
        end
        step(0, 0, 0, 0, 0, 0, 0, 1, ga, gb);
        chk("cnt_after_4", bus.contention_cnt, 4);
        chk("cnt2_saturated", bus2.contention_cnt, 3);
        step(1, 1, 1, 1, 2, 2, 0, 1, ga, gb);
        step(1, 1, 1, 1, 2, 2, 0, 1, ga, gb);
        chk("cnt2_holds", bus2.contention_cnt, 3);

        // Stalled write to register 7 freezes the slot.
        step(1, 7, 32'h77, 0, 0, 0, 0, 1, ga, gb);
        chk("r7_accept", ga, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 32'h11, 1, 2, 32'h22, 1, 1, ga, gb);
            chk("stall_no_ready", ga | gb, 0);
            chk("stall_frozen_addr", bus.wr_addr, 7);
        end
        step(1, 1, 32'h11, 1, 2, 32'h22, 0, 1, ga, gb);
        chk("stall_release_grant_b", gb, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1, ga, gb);
        chk("after_release_addr", bus.wr_addr, 2);

        // Register-0 write from B.
        step(0, 0, 0, 1, 0, 32'h1234, 0, 1, ga, gb);
        chk("zero_b_ready", gb, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1, ga, gb);
        chk("zero_wr_en", bus.wr_en, !DROP0);

        // Reset during a stalled write to register 9.
        step(1, 9, 32'h99, 0, 0, 0, 0, 1, ga, gb);
        step(0, 0, 0, 0, 0, 0, 1, 1, ga, gb);
        step(1, 1, 1, 1, 2, 2, 1, 0, ga, gb);
        chk("reset_no_ready", ga | gb, 0);
        step(1, 1, 1, 1, 2, 2, 1, 1, ga, gb);
        chk("reset_discard", bus.wr_en, 0);
        chk("reset_tie_a", ga, 1);

        // Randomised traffic; requests are held until accepted.
        pa = 0; pb = 0; ra = '0; rb = '0; da = '0; db = '0;
        for (int n = 0; n < 400; n++) begin
            if (!pa && $urandom_range(0, 99) < 60) begin
                pa = 1; ra = AW'($urandom); da = $urandom;
            end
            if (!pb && $urandom_range(0, 99) < 60) begin
                pb = 1; rb = AW'($urandom); db = $urandom;
            end
            st = ($urandom_range(0, 99) < 30);
            step(pa, ra, da, pb, rb, db, st, 1, ga, gb);
            if (ga) pa = 0;
            if (gb) pb = 0;
        end
        step(0, 0, 0, 0, 0, 0, 0, 1, ga, gb);
        step(0, 0, 0, 0, 0, 0, 0, 1, ga, gb);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_regfile_wr_arbiter

`default_nettype wire
